// File: rtl/player_pkg.sv
// Shared key codes, direction/jump state encodings and the registered command
// bundle for the player movement encoder.
package player_pkg;

    localparam int NUM_KEYS = 4;
    localparam int K_L = 0;
    localparam int K_R = 1;
    localparam int K_D = 2;
    localparam int K_J = 3;

    localparam logic [7:0] DEF_KEY_LEFT  = 8'h04;
    localparam logic [7:0] DEF_KEY_RIGHT = 8'h07;
    localparam logic [7:0] DEF_KEY_DOWN  = 8'h16;
    localparam logic [7:0] DEF_KEY_JUMP  = 8'h1A;
    localparam logic [7:0] KEY_NONE      = 8'h00;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        J_IDLE = 2'd0,
        J_FIRE = 2'd1,
        J_COOL = 2'd2,
        J_WAIT = 2'd3
    } jump_state_t;

    typedef struct packed {
        logic [7:0] keycode;
        logic       jump_pulse;
        logic       jump_busy;
        dir_t       dir;
    } cmd_t;

endpackage

// File: rtl/key_hold_filter.sv
// Single-key presence detector with a release debounce: a press is seen at once,
// a release only after RELEASE_FRAMES consecutive absent frames.
module key_hold_filter #(
    parameter int         RELEASE_FRAMES = 2,
    parameter logic [7:0] KEY_CODE       = 8'h00
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycodes_raw,
    output logic        held,
    output logic        rise
);

    localparam int CW = $clog2(RELEASE_FRAMES + 1);
    localparam logic [CW-1:0] RF_C = CW'(RELEASE_FRAMES);

    logic          present;
    logic          held_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        present = 1'b0;
        for (int s = 0; s < 4; s++)
            if (keycodes_raw[s*8 +: 8] == KEY_CODE) present = 1'b1;
    end

    // held is the next-state value so the top can act on the same edge
    always_comb begin
        cnt_d = cnt_q;
        held  = held_q;
        if (present) begin
            cnt_d = '0;
            held  = 1'b1;
        end else begin
            if (cnt_q != RF_C) cnt_d = cnt_q + 1'b1;
            if (cnt_d == RF_C) held = 1'b0;
        end
    end

    assign rise = held & ~held_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held;
        end
    end

endmodule

// File: rtl/player_cmd_encoder.sv
// Encodes the raw HID keycode word into one movement keycode per frame, with
// last-pressed left/right arbitration and a one-shot, cooled-down jump.
module player_cmd_encoder
    import player_pkg::*;
#(
    parameter int         RELEASE_FRAMES = 2,
    parameter int         JUMP_COOLDOWN  = 64,
    parameter logic [7:0] KEY_LEFT       = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT      = DEF_KEY_RIGHT,
    parameter logic [7:0] KEY_DOWN       = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_JUMP       = DEF_KEY_JUMP
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycodes_raw,
    output logic [7:0]  keycode,
    output logic        jump_pulse,
    output logic        jump_busy,
    output logic [1:0]  dir_state
);

    localparam int CNT_W = $clog2(JUMP_COOLDOWN);
    localparam logic [NUM_KEYS-1:0][7:0] KEY_CODES = {KEY_JUMP, KEY_DOWN, KEY_RIGHT, KEY_LEFT};

    logic [NUM_KEYS-1:0] held, rise;

    dir_t              h_q, h_d;
    jump_state_t       j_q, j_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_hold_filter #(
            .RELEASE_FRAMES (RELEASE_FRAMES),
            .KEY_CODE       (KEY_CODES[k])
        ) u_filt (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .keycodes_raw (keycodes_raw),
            .held         (held[k]),
            .rise         (rise[k])
        );
    end

    always_comb begin
        h_d   = h_q;
        j_d   = j_q;
        cnt_d = '0;
        cmd_d = '0;

        // a fresh press always wins; right wins a simultaneous press
        if (rise[K_R])      h_d = DIR_RIGHT;
        else if (rise[K_L]) h_d = DIR_LEFT;
        else begin
            case (h_q)
                DIR_LEFT:  if (!held[K_L]) h_d = held[K_R] ? DIR_RIGHT : DIR_NONE;
                DIR_RIGHT: if (!held[K_R]) h_d = held[K_L] ? DIR_LEFT : DIR_NONE;
                default:   h_d = held[K_R] ? DIR_RIGHT : (held[K_L] ? DIR_LEFT : DIR_NONE);
            endcase
        end

        case (j_q)
            J_IDLE: if (rise[K_J]) j_d = J_FIRE;
            J_FIRE: begin
                j_d   = J_COOL;
                cnt_d = CNT_W'(JUMP_COOLDOWN - 1);
            end
            J_COOL: begin
                if (cnt_q == '0) j_d = held[K_J] ? J_WAIT : J_IDLE;
                else             cnt_d = cnt_q - 1'b1;
            end
            J_WAIT: if (!held[K_J]) j_d = J_IDLE;
            default: j_d = J_IDLE;
        endcase

        cmd_d.jump_pulse = (j_d == J_FIRE);
        cmd_d.jump_busy  = (j_d == J_COOL) || (j_d == J_WAIT);
        cmd_d.dir        = h_d;
        if (j_d == J_FIRE)        cmd_d.keycode = KEY_JUMP;
        else if (h_d == DIR_LEFT)  cmd_d.keycode = KEY_LEFT;
        else if (h_d == DIR_RIGHT) cmd_d.keycode = KEY_RIGHT;
        else if (held[K_D])        cmd_d.keycode = KEY_DOWN;
        else                       cmd_d.keycode = KEY_NONE;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            h_q   <= DIR_NONE;
            j_q   <= J_IDLE;
            cnt_q <= '0;
            cmd_q <= '0;
        end else begin
            h_q   <= h_d;
            j_q   <= j_d;
            cnt_q <= cnt_d;
            cmd_q <= cmd_d;
        end
    end

    assign keycode    = cmd_q.keycode;
    assign jump_pulse = cmd_q.jump_pulse;
    assign jump_busy  = cmd_q.jump_busy;
    assign dir_state  = cmd_q.dir;

endmodule

// File: tb/tb_player_cmd_encoder.sv
// Scenario bench for player_cmd_encoder: expected per-frame outputs are queued
// as each frame is driven and compared once the frame's edge has passed.
module tb_player_cmd_encoder;
    import player_pkg::*;

    typedef struct packed {
        logic [7:0] key;
        logic       pulse;
        logic       busy;
        logic [1:0] dir;
    } obs_t;

    logic        frame_clk;
    logic        Reset;
    logic [31:0] keycodes_raw;
    logic [7:0]  keycode;
    logic        jump_pulse;
    logic        jump_busy;
    logic [1:0]  dir_state;

    int checks   = 0;
    int failures = 0;
    obs_t exp_q[$];

    player_cmd_encoder dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycodes_raw (keycodes_raw),
        .keycode      (keycode),
        .jump_pulse   (jump_pulse),
        .jump_busy    (jump_busy),
        .dir_state    (dir_state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic obs_t mk(logic [7:0] k, logic p, logic b, logic [1:0] d);
        obs_t o;
        o.key = k; o.pulse = p; o.busy = b; o.dir = d;
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(keycode, jump_pulse, jump_busy, dir_state);
    endfunction

    task automatic apply_reset();
        Reset = 1'b1;
        keycodes_raw = 32'h0;
        repeat (2) @(negedge frame_clk);
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        obs_t e, got;
        Reset = 1'b1;
        keycodes_raw = 32'h0;
        #1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0));
        @(posedge frame_clk); #1;
        e = exp_q.pop_front(); got = cur();
        checks++;
        if (got !== e) begin failures++; $display("FAIL reset got=%h exp=%h", got, e); end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset_mid_cool();
        obs_t e, got;
        apply_reset();
        for (int f = 0; f < 10; f++) begin
            keycodes_raw = 32'h0000_001A;
            exp_q.push_back(f == 0 ? mk(8'h1A, 1'b1, 1'b0, 2'd0) : mk(8'h00, 1'b0, 1'b1, 2'd0));
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL rst_cool f%0d got=%h exp=%h", f, got, e); end
        end
        // asynchronous abort between edges
        #2 Reset = 1'b1;
        #1;
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0));
        e = exp_q.pop_front(); got = cur();
        checks++;
        if (got !== e) begin failures++; $display("FAIL rst_async got=%h exp=%h", got, e); end
        checks++;
        if (dut.j_q !== J_IDLE || dut.cnt_q !== '0) begin
            failures++;
            $display("FAIL rst_state got=%0d/%0d exp=%0d/0", dut.j_q, dut.cnt_q, J_IDLE);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
        keycodes_raw = 32'h0000_001A;
        exp_q.push_back(mk(8'h1A, 1'b1, 1'b0, 2'd0));
        @(posedge frame_clk); #1;
        e = exp_q.pop_front(); got = cur();
        checks++;
        if (got !== e) begin failures++; $display("FAIL rst_refire got=%h exp=%h", got, e); end
    endtask

    task automatic test_jump_hold();
        obs_t e, got;
        apply_reset();
        for (int f = 0; f < 203; f++) begin
            keycodes_raw = (f < 200 || f == 202) ? 32'h1A00_0000 : 32'h0;
            if (f == 0 || f == 202)  exp_q.push_back(mk(8'h1A, 1'b1, 1'b0, 2'd0));
            else if (f <= 200)       exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 2'd0));
            else                     exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0));
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL jump_hold f%0d got=%h exp=%h", f, got, e); end
        end
    endtask

    task automatic test_jump_cool_repress();
        obs_t e, got;
        apply_reset();
        // release and re-press inside the cooldown must not fire again
        for (int f = 0; f < 72; f++) begin
            keycodes_raw = (f >= 1 && f <= 3) ? 32'h0 : 32'h0000_1A00;
            exp_q.push_back(f == 0 ? mk(8'h1A, 1'b1, 1'b0, 2'd0) : mk(8'h00, 1'b0, 1'b1, 2'd0));
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL jump_repress f%0d got=%h exp=%h", f, got, e); end
        end
        checks++;
        if (dut.j_q !== J_WAIT) begin failures++; $display("FAIL jump_wait got=%0d exp=%0d", dut.j_q, J_WAIT); end
    endtask

    task automatic test_lr_conflict();
        obs_t e, got;
        apply_reset();
        for (int f = 0; f < 17; f++) begin
            if (f < 5)        keycodes_raw = 32'h0000_0004;
            else if (f < 10)  keycodes_raw = 32'h0000_0704;
            else if (f < 14)  keycodes_raw = 32'h0000_0004;
            else              keycodes_raw = 32'h0;
            if (f >= 5 && f <= 10) exp_q.push_back(mk(8'h07, 1'b0, 1'b0, 2'd2));
            else if (f <= 14)      exp_q.push_back(mk(8'h04, 1'b0, 1'b0, 2'd1));
            else                   exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0));
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL lr f%0d got=%h exp=%h", f, got, e); end
        end
        // simultaneous press resolves to right
        keycodes_raw = 32'h0004_0700;
        exp_q.push_back(mk(8'h07, 1'b0, 1'b0, 2'd2));
        @(posedge frame_clk); #1;
        e = exp_q.pop_front(); got = cur();
        checks++;
        if (got !== e) begin failures++; $display("FAIL lr_both got=%h exp=%h", got, e); end
    endtask

    task automatic test_glitch();
        obs_t e, got;
        logic [31:0] raw_t [7] = '{32'h07, 32'h07, 32'h07, 32'h0, 32'h07, 32'h0, 32'h0};
        obs_t exp_t [7];
        for (int f = 0; f < 7; f++) exp_t[f] = mk(8'h07, 1'b0, 1'b0, 2'd2);
        exp_t[6] = mk(8'h00, 1'b0, 1'b0, 2'd0);
        apply_reset();
        for (int f = 0; f < 7; f++) begin
            keycodes_raw = raw_t[f];
            exp_q.push_back(exp_t[f]);
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL glitch f%0d got=%h exp=%h", f, got, e); end
        end
    endtask

    task automatic test_priority();
        obs_t e, got;
        logic [31:0] raw_t [6] = '{32'h001A_0716, 32'h001A_0716, 32'h001A_0716,
                                   32'h001A_0016, 32'h001A_0016, 32'h001A_0016};
        obs_t exp_t [6];
        exp_t[0] = mk(8'h1A, 1'b1, 1'b0, 2'd2);
        exp_t[1] = mk(8'h07, 1'b0, 1'b1, 2'd2);
        exp_t[2] = mk(8'h07, 1'b0, 1'b1, 2'd2);
        exp_t[3] = mk(8'h07, 1'b0, 1'b1, 2'd2);
        exp_t[4] = mk(8'h16, 1'b0, 1'b1, 2'd0);
        exp_t[5] = mk(8'h16, 1'b0, 1'b1, 2'd0);
        apply_reset();
        for (int f = 0; f < 6; f++) begin
            keycodes_raw = raw_t[f];
            exp_q.push_back(exp_t[f]);
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL prio f%0d got=%h exp=%h", f, got, e); end
        end
    endtask

    task automatic test_dup_unknown();
        obs_t e, got;
        logic [31:0] raw_t [5] = '{32'h0404_2C00, 32'h0404_2C00, 32'h2C2C_2C2C,
                                   32'h2C2C_2C2C, 32'h2C2C_2C2C};
        obs_t exp_t [5];
        exp_t[0] = mk(8'h04, 1'b0, 1'b0, 2'd1);
        exp_t[1] = mk(8'h04, 1'b0, 1'b0, 2'd1);
        exp_t[2] = mk(8'h04, 1'b0, 1'b0, 2'd1);
        exp_t[3] = mk(8'h00, 1'b0, 1'b0, 2'd0);
        exp_t[4] = mk(8'h00, 1'b0, 1'b0, 2'd0);
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            keycodes_raw = raw_t[f];
            exp_q.push_back(exp_t[f]);
            @(posedge frame_clk); #1;
            e = exp_q.pop_front(); got = cur();
            checks++;
            if (got !== e) begin failures++; $display("FAIL dup f%0d got=%h exp=%h", f, got, e); end
        end
    endtask

    initial begin
        Reset = 1'b1;
        keycodes_raw = 32'h0;
        test_reset();
        test_reset_mid_cool();
        test_jump_hold();
        test_jump_cool_repress();
        test_lr_conflict();
        test_glitch();
        test_priority();
        test_dup_unknown();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_cmd_encoder.md
Name: player_cmd_encoder

Overview:
- Produces the single 8-bit movement keycode consumed by the player movement controller, one value per frame_clk tick.
- Input is the raw 4-slot USB HID keycode word.
- Resolves A/D conflicts by last-pressed priority and filters USB release glitches.
- Turns W into a one-frame jump command, followed by a cooldown and a must-release rule, so holding W never re-triggers a jump.

Parameters:
- RELEASE_FRAMES, 2: consecutive absent frames before a held key counts as released (1..3).
- JUMP_COOLDOWN, 64: frames after a jump pulse during which a new jump is suppressed. Covers the 63-frame jump arc.
- KEY_LEFT, 8'h04: left key code.
- KEY_RIGHT, 8'h07: right key code.
- KEY_DOWN, 8'h16: down key code.
- KEY_JUMP, 8'h1A: jump key code.

Ports:
- frame_clk  in  1  vertical-sync-rate clock
- Reset  in  1  asynchronous, active-high
- keycodes_raw  in  32  four HID key slots, [7:0] slot0 .. [31:24] slot3; 8'h00 = empty
- keycode  out  8  encoded command to movement controller
- jump_pulse  out  1  high exactly one frame when a jump fires
- jump_busy  out  1  high during cooldown or wait-for-release
- dir_state  out  2  0 none, 1 left, 2 right

Behaviour:
- Reset: Reset is asynchronous, active-high; clock is frame_clk.
  - Outputs on reset: keycode=8'h00, jump_pulse=0, jump_busy=0, dir_state=0.
  - Internal state on reset: all release counters 0, all held flags 0, jump FSM J_IDLE, horizontal FSM H_NONE, cooldown counter 0.
  - Reset asserted mid-jump or mid-cooldown aborts to these values immediately.
- Presence: key k is present if any of the 4 slots equals its code. Duplicate slots count once.
- Held filter, per key (L, R, D, J):
  - Present: held=1 and the absent counter clears.
  - Absent: the counter increments, saturating at RELEASE_FRAMES. held drops to 0 on the edge where the counter reaches RELEASE_FRAMES.
  - Press takes effect on the same edge it is sampled.
- Rising edge: held_next & ~held_q, per key.
- Horizontal FSM (H_NONE, H_LEFT, H_RIGHT):
  - L rise -> H_LEFT; R rise -> H_RIGHT. If both rise on the same edge -> H_RIGHT.
  - Current-direction key released and the other still held -> switch to the other direction.
  - Both released -> H_NONE.
- Jump FSM (J_IDLE, J_FIRE, J_COOL, J_WAIT):
  - J_IDLE: J rise -> J_FIRE.
  - J_FIRE: lasts one frame; jump_pulse=1; loads the counter with JUMP_COOLDOWN-1; -> J_COOL.
  - J_COOL: decrements the counter. At 0: J held -> J_WAIT, else -> J_IDLE.
  - J_WAIT: J released -> J_IDLE.
  - jump_busy=1 in J_COOL and J_WAIT.
  - J rises during J_COOL or J_WAIT are ignored. No buffering.
- Keycode priority, all outputs registered:
  - jump state is J_FIRE -> KEY_JUMP
  - else H_LEFT -> KEY_LEFT
  - else H_RIGHT -> KEY_RIGHT
  - else D held -> KEY_DOWN
  - else 8'h00
- Latency: a key present before edge N appears in keycode after edge N. A jump pulse occupies exactly one frame.
- Unknown codes in keycodes_raw are ignored.
- Counter width: clog2(JUMP_COOLDOWN). The counter never wraps; it is held at 0 outside J_COOL.

Decomposition:
- Shared package player_pkg holds:
  - key code constants
  - dir_t enum (DIR_NONE, DIR_LEFT, DIR_RIGHT)
  - jump_state_t enum
- One sub-module, key_hold_filter: a single-key presence detector plus release counter, instantiated 4 times. It outputs held and rise.

Test Plan:
1. Reset mid-cooldown: fire a jump, assert Reset at frame 10 -> all outputs 0 and state J_IDLE immediately. After release, raw 8'h1A -> keycode 8'h1A on the next edge.
2. Hold W 200 frames -> keycode 8'h1A on exactly frame 1, jump_pulse single frame, jump_busy high frames 2..200. No second pulse until W is released for 2 frames and pressed again.
3. Left/right conflict: press A (frame 0), add D (frame 5), release D (frame 10) -> keycode 8'h04, then 8'h07 at frame 5, then 8'h04 after frame 11. D is released at frame 11 with RELEASE_FRAMES=2.
4. Glitch: D held, raw drops to 32'h0 for one frame -> keycode stays 8'h07. Drop for two frames -> 8'h00 on the second edge.
5. Priority: raw 32'h00_1A_07_16 from idle -> frame 1 keycode 8'h1A, frame 2 8'h07. Then remove 07 -> after release, 8'h16.
6. Duplicate and unknown slots: raw 32'h04_04_2C_00 -> keycode 8'h04, dir_state 1. Raw 32'h2C2C2C2C -> 8'h00 after RELEASE_FRAMES.
